mnist_frame_loader: RTL and testbench

Host-side initiator for the MNIST runner's image write port. It accepts a byte stream of four 28×28 images (784 pixels each, digit-major, row-major) over a valid/ready handshake and issues one write per pixel on the runner's write interface. After a fixed settling delay it snapshots the four classified digits and returns them as four ASCII result bytes over a second valid/ready stream. It sits between the byte transport (UART/bridge) and the runner.

---
 rtl/mnist_frame_loader.sv | 154 +++++++++++++++
 tb/tb_mnist_frame_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_frame_loader.sv
// mnist_frame_loader
// Takes a byte stream of four 28x28 images, writes each pixel into the MNIST
// runner's image memory, waits for the classifier to settle, then returns the
// four classified digits as ASCII result bytes.
// Optional build macro: MNIST_LOADER_THRESHOLD_EN binarizes each pixel against
// THRESHOLD before it is written (default build passes bytes through raw).
module mnist_frame_loader #(
    parameter int         PIXELS         = 784,
    parameter int         DIGITS         = 4,
    parameter int         RESULT_LATENCY = 8,
    parameter logic [7:0] THRESHOLD      = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       write_enable,
    output logic [1:0] write_digit,
    output logic [9:0] write_addr,
    output logic [7:0] write_data,
    input  logic [3:0] digit [0:3],
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    localparam int WAIT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [9:0]        pix_cnt;
    logic [1:0]        dig_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        res_idx;
    logic [3:0]        snapshot [0:3];
    logic [3:0]        res_sel;
    logic [7:0]        pixel_val;
    logic              accept;
    logic              out_fire;
    logic              pix_last;
    logic              frame_last;

    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign pix_last   = (pix_cnt == 10'(PIXELS - 1));
    assign frame_last = pix_last && (dig_cnt == 2'(DIGITS - 1));
    assign res_sel    = snapshot[res_idx];

`ifdef MNIST_LOADER_THRESHOLD_EN
    assign pixel_val = (in_data >= THRESHOLD) ? 8'h01 : 8'h00;
`else
    assign pixel_val = in_data;
`endif

    // State register; reset always lands in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: full frame -> WAIT, settle count done -> SEND, last result -> LOAD.
    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (accept && frame_last) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_fire && (res_idx == 2'd3)) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Handshake outputs come straight from the state register (and rst for in_ready).
    always_comb begin
        in_ready  = (state == LOAD) && !rst;
        out_valid = (state == SEND);
        out_data  = 8'h00;
        if (state == SEND) begin
            out_data = (res_sel <= 4'd9) ? (8'h30 + {4'h0, res_sel}) : 8'h3F;
        end
    end

    // Pixel/digit counters, runner write port, settle counter, snapshot and result index.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt      <= '0;
            dig_cnt      <= '0;
            wait_cnt     <= '0;
            res_idx      <= '0;
            write_enable <= 1'b0;
            write_digit  <= '0;
            write_addr   <= '0;
            write_data   <= '0;
            busy         <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snapshot[i] <= '0;
            end
        end else begin
            write_enable <= accept;
            if (accept) begin
                write_digit <= dig_cnt;
                write_addr  <= pix_cnt;
                write_data  <= pixel_val;
                if (pix_last) begin
                    pix_cnt <= '0;
                    dig_cnt <= dig_cnt + 2'd1;
                end else begin
                    pix_cnt <= pix_cnt + 10'd1;
                end
            end

            if ((state == LOAD) && (state_next == WAIT)) begin
                wait_cnt <= WAIT_W'(RESULT_LATENCY - 1);
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if ((state == WAIT) && (wait_cnt == '0)) begin
                for (int i = 0; i < 4; i++) begin
                    snapshot[i] <= digit[i];
                end
            end

            if (out_fire) begin
                res_idx <= res_idx + 2'd1;
            end

            busy <= (state_next != LOAD);
        end
    end

endmodule

// File: tb/tb_mnist_frame_loader.sv
// Testbench for mnist_frame_loader: table-driven frames with hand-computed
// result bytes plus a per-cycle reference model of the loader's outputs.
module tb_mnist_frame_loader;

    localparam int PIXELS  = 784;
    localparam int FRAME   = 4 * PIXELS;
    localparam int LATENCY = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       write_enable;
    logic [1:0] write_digit;
    logic [9:0] write_addr;
    logic [7:0] write_data;
    logic [3:0] digit [0:3];
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [3:0][3:0] dig;
        logic [3:0][7:0] exp;
        logic [7:0]      ready_pat;
        bit              duty30;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [1:0] d;
        logic [9:0] a;
        logic [7:0] data;
    } wr_t;

    vec_t       vecs [3];
    wr_t        wr_log [$];
    logic [7:0] thr_exp [4];
    int         ov_rise_cycle = 0;
    logic       ov_prev = 1'b0;

    // Reference model state (values after the most recent clock edge)
    int         m_state = 0;
    int         m_pix = 0;
    int         m_wait = 0;
    logic [1:0] m_k = 2'd0;
    logic [3:0] m_snap [4];
    logic       m_we = 1'b0;
    logic [1:0] m_wd = 2'd0;
    logic [9:0] m_wa = 10'd0;
    logic [7:0] m_wdat = 8'd0;
    logic       m_busy = 1'b0;

    mnist_frame_loader #(
        .PIXELS(PIXELS),
        .DIGITS(4),
        .RESULT_LATENCY(LATENCY),
        .THRESHOLD(8'd128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .write_enable(write_enable),
        .write_digit(write_digit),
        .write_addr(write_addr),
        .write_data(write_data),
        .digit(digit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pixel(input int i);
        case (i)
            0: pixel = 8'd127;
            1: pixel = 8'd128;
            2: pixel = 8'd255;
            3: pixel = 8'd0;
            default: pixel = 8'((i * 7 + 3) & 255);
        endcase
    endfunction

    function automatic logic [7:0] xform(input logic [7:0] b);
`ifdef MNIST_LOADER_THRESHOLD_EN
        xform = (b >= 8'd128) ? 8'h01 : 8'h00;
`else
        xform = b;
`endif
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        to_ascii = (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle model comparison and prediction of the next cycle
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("m_in_ready", in_ready, (m_state == 0) && !rst);
            checkOutput("m_write_enable", write_enable, m_we);
            if (m_we) begin
                checkOutput("m_write_digit", write_digit, m_wd);
                checkOutput("m_write_addr", write_addr, m_wa);
                checkOutput("m_write_data", write_data, m_wdat);
            end
            checkOutput("m_out_valid", out_valid, m_state == 2);
            checkOutput("m_out_data", out_data, (m_state == 2) ? to_ascii(m_snap[m_k]) : 8'h00);
            checkOutput("m_busy", busy, m_busy);

            if (write_enable) begin
                wr_log.push_back('{cyc, write_digit, write_addr, write_data});
            end
            if (out_valid && !ov_prev) begin
                ov_rise_cycle = cyc;
            end
            ov_prev = out_valid;

            if (rst) begin
                m_state = 0; m_pix = 0; m_wait = 0; m_k = 2'd0;
                m_we = 1'b0; m_wd = 2'd0; m_wa = 10'd0; m_wdat = 8'd0;
                for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
            end else begin
                m_we = 1'b0;
                if (m_state == 0) begin
                    if (in_valid) begin
                        m_we   = 1'b1;
                        m_wd   = 2'(m_pix / PIXELS);
                        m_wa   = 10'(m_pix % PIXELS);
                        m_wdat = xform(in_data);
                        m_pix++;
                        if (m_pix == FRAME) begin
                            m_pix   = 0;
                            m_state = 1;
                            m_wait  = LATENCY - 1;
                        end
                    end
                end else if (m_state == 1) begin
                    if (m_wait == 0) begin
                        for (int i = 0; i < 4; i++) m_snap[i] = digit[i];
                        m_state = 2;
                        m_k     = 2'd0;
                    end else begin
                        m_wait--;
                    end
                end else begin
                    if (out_ready) begin
                        if (m_k == 2'd3) m_state = 0;
                        m_k = m_k + 2'd1;
                    end
                end
            end
            m_busy = !rst && (m_state != 0);
        end
    end

    // Push nbytes of the frame pattern through the input handshake
    task automatic applyStimulus(input int nbytes, input bit duty30);
        int sent  = 0;
        int guard = 0;
        while (sent < nbytes && guard < 20000) begin
            @(posedge clk); #1;
            if (!duty30 || ($urandom_range(99) < 30)) begin
                in_valid = 1'b1;
                in_data  = pixel(sent);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom_range(255));
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("accept_count", sent, nbytes);
    endtask

    // Drain the four result bytes following the vector's out_ready pattern
    task automatic collectResults(input int v);
        int guard = 0;
        int n = 0;
        int c = 0;
        int tcyc [4];
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 40);
        checkOutput($sformatf("v%0d_out_valid_seen", v), out_valid, 1);
        for (int i = 0; i < 4; i++) digit[i] = 4'hE;
        while (n < 4 && c < 60) begin
            if (out_valid && out_ready) begin
                checkOutput($sformatf("v%0d_byte%0d", v, n), out_data, vecs[v].exp[n]);
                tcyc[n] = cyc;
                n++;
            end
            if (n < 4) begin
                @(posedge clk); #1;
                c++;
                out_ready = vecs[v].ready_pat[(c > 7) ? 7 : c];
                @(negedge clk);
            end
        end
        checkOutput($sformatf("v%0d_result_count", v), n, 4);
        if (n == 4 && vecs[v].ready_pat == 8'hFF) begin
            checkOutput($sformatf("v%0d_zero_bubble", v), tcyc[3] - tcyc[0], 3);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Whole-frame checks on the write log of the frame starting at log index base
    task automatic checkFrame(input int v, input int base);
        int errs = 0;
        int last;
        checkOutput($sformatf("v%0d_write_count", v), wr_log.size() - base, FRAME);
        if (wr_log.size() - base == FRAME) begin
            last = base + FRAME - 1;
            checkOutput($sformatf("v%0d_first_write", v), {wr_log[base].d, wr_log[base].a}, 12'h000);
            checkOutput($sformatf("v%0d_last_write", v), {wr_log[last].d, wr_log[last].a}, {2'd3, 10'd783});
            checkOutput($sformatf("v%0d_wrap_783", v), {wr_log[base+783].d, wr_log[base+783].a}, {2'd0, 10'd783});
            checkOutput($sformatf("v%0d_wrap_next", v), {wr_log[base+784].d, wr_log[base+784].a}, {2'd1, 10'd0});
            for (int i = 0; i < FRAME; i++) begin
                if (int'(wr_log[base+i].d) * PIXELS + int'(wr_log[base+i].a) != i) errs++;
            end
            checkOutput($sformatf("v%0d_sequential_addr", v), errs, 0);
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("v%0d_thr_pixel%0d", v, i), wr_log[base+i].data, thr_exp[i]);
            end
            if (!vecs[v].duty30) begin
                checkOutput($sformatf("v%0d_consecutive", v), wr_log[last].cyc - wr_log[base].cyc, FRAME - 1);
            end
            checkOutput($sformatf("v%0d_latency", v), ov_rise_cycle - wr_log[last].cyc, LATENCY);
        end
    endtask

    initial begin
        int base;
        vecs[0].dig = {4'd0, 4'd1, 4'd2, 4'd7};
        vecs[0].exp = {8'h30, 8'h31, 8'h32, 8'h37};
        vecs[0].ready_pat = 8'hFF;
        vecs[0].duty30 = 1'b0;
        vecs[1].dig = {4'd3, 4'd15, 4'd9, 4'd12};
        vecs[1].exp = {8'h33, 8'h3F, 8'h39, 8'h3F};
        vecs[1].ready_pat = 8'hE9;
        vecs[1].duty30 = 1'b1;
        vecs[2].dig = {4'd8, 4'd5, 4'd0, 4'd10};
        vecs[2].exp = {8'h38, 8'h35, 8'h30, 8'h3F};
        vecs[2].ready_pat = 8'hFF;
        vecs[2].duty30 = 1'b0;
`ifdef MNIST_LOADER_THRESHOLD_EN
        thr_exp[0] = 8'h00; thr_exp[1] = 8'h01; thr_exp[2] = 8'h01; thr_exp[3] = 8'h00;
`else
        thr_exp[0] = 8'd127; thr_exp[1] = 8'd128; thr_exp[2] = 8'd255; thr_exp[3] = 8'd0;
`endif
        for (int i = 0; i < 4; i++) begin
            m_snap[i] = 4'd0;
            digit[i]  = 4'd0;
        end

        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_write_enable", write_enable, 0);
        checkOutput("rst_write_fields", {write_digit, write_addr, write_data}, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 1);
        checkOutput("post_rst_write_enable", write_enable, 0);

        for (int v = 0; v < 3; v++) begin
            if (v == 2) begin
                $display("[TB] reset in the middle of image 2");
                applyStimulus(2 * PIXELS + 400, 1'b0);
                rst = 1'b1;
                in_valid = 1'b1;
                in_data = 8'h55;
                @(posedge clk); #1;
                rst = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                checkOutput("midrst_write_enable", write_enable, 0);
                checkOutput("midrst_busy", busy, 0);
            end
            $display("[TB] frame vector %0d", v);
            for (int i = 0; i < 4; i++) digit[i] = vecs[v].dig[i];
            out_ready = vecs[v].ready_pat[0];
            base = wr_log.size();
            applyStimulus(FRAME, vecs[v].duty30);
            in_valid = 1'b1;
            in_data  = 8'hC3;
            repeat (3) @(posedge clk);
            #1;
            in_valid = 1'b0;
            collectResults(v);
            repeat (3) @(posedge clk);
            #1;
            checkFrame(v, base);
            @(negedge clk);
            checkOutput($sformatf("v%0d_back_to_load", v), {in_ready, busy}, 2'b10);
        end

        repeat (2) @(posedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
